// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative unsigned multiply / divide unit for the EX stage.
//             One bit per clock: shift-add for MUL/UMULH, restoring
//             shift-subtract for UDIV. Holds the pipeline via stall_E until
//             the result is ready.
//  Ports    : clk, reset  - clock, synchronous active-high reset
//             start       - request from EX (sampled only in IDLE)
//             op          - 00 MUL, 01 UMULH, 10 UDIV, 11 MUL
//             srcA, srcB  - multiplicand/dividend, multiplier/divisor
//             flush       - abort any operation in flight
//             result      - registered result, held until next completion
//             done        - one-cycle result-valid pulse
//             busy        - unit not idle
//             stall_E     - pipeline hold request
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int N     = 64,
  parameter int CNT_W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  input  logic         flush,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         stall_E
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       c_OP_UMULH = 2'b01;
  localparam logic [1:0]       c_OP_UDIV  = 2'b10;
  localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [N-1:0]     r_opa;     // multiplicand (MUL) / dividend shifting left (UDIV)
  logic [N-1:0]     r_opb;     // multiplier shifting right (MUL) / divisor (UDIV)
  logic [2*N-1:0]   r_acc;     // product (MUL); low half collects quotient (UDIV)
  logic [N:0]       r_rem;     // partial remainder
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_result;

  logic             w_accept;
  logic             w_div0;
  logic             w_is_div;
  logic [N:0]       w_sum;
  logic [2*N-1:0]   w_prod_next;
  logic [N+1:0]     w_trial;
  logic [N+1:0]     w_diff;
  logic             w_borrow;
  logic [N:0]       w_rem_next;
  logic [N-1:0]     w_quot_next;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_div0   = w_accept && (op == c_OP_UDIV) && (srcB == '0);
  assign w_is_div = (r_op == c_OP_UDIV);

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  assign w_sum       = {1'b0, r_acc[2*N-1:N]} + ({1'b0, r_opa} & {(N+1){r_opb[0]}});
  assign w_prod_next = {w_sum, r_acc[N-1:1]};

  // Restoring divide step: bring in the next dividend bit, trial-subtract the
  // divisor; the extra top bit of the difference is the borrow.
  assign w_trial     = {1'b0, r_rem[N-1:0], r_opa[N-1]} | {r_rem[N], {(N+1){1'b0}}};
  assign w_diff      = w_trial - {2'b00, r_opb};
  assign w_borrow    = w_diff[N+1];
  assign w_rem_next  = w_borrow ? w_trial[N:0] : w_diff[N:0];
  assign w_quot_next = {r_acc[N-2:0], ~w_borrow};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and control outputs
  always_comb begin
    w_next  = r_state;
    done    = 1'b0;
    stall_E = 1'b0;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        stall_E = w_accept;
        if (w_accept) w_next = w_div0 ? S_DONE : S_RUN;
      end
      S_RUN: begin
        stall_E = 1'b1;
        if (flush)               w_next = S_IDLE;
        else if (r_cnt == c_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        done   = !flush;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_opa <= srcA;
            r_opb <= srcB;
            r_acc <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            if (w_div0) r_result <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_is_div) begin
            r_rem <= w_rem_next;
            r_acc <= {r_acc[2*N-1:N], w_quot_next};
            r_opa <= r_opa << 1;
          end else begin
            r_acc <= w_prod_next;
            r_opb <= r_opb >> 1;
          end
          // The final iteration's value goes straight into the result so
          // DONE presents it without an extra cycle.
          if ((r_cnt == c_LAST) && !flush) begin
            case (r_op)
              c_OP_UMULH: r_result <= w_prod_next[2*N-1:N];
              c_OP_UDIV:  r_result <= w_quot_next;
              default:    r_result <= w_prod_next[N-1:0];
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer: directed vector
//             table, hand-written flush/reset/protocol sequences, and random
//             operations against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] srcA;
  logic [N-1:0] srcB;
  logic         flush;
  logic [N-1:0] result;
  logic         done;
  logic         busy;
  logic         stall_E;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.N(N), .CNT_W(7)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .srcA    (srcA),
    .srcB    (srcB),
    .flush   (flush),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .stall_E (stall_E)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain wide arithmetic.
  function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    case (o)
      2'b01:   return p[2*N-1:N];
      2'b10:   return (b == '0) ? '0 : a / b;
      default: return p[N-1:0];
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [N-1:0] b);
    return (o == 2'b10 && b == '0) ? 1 : N + 1;
  endfunction

  // Issue one operation. Cycle 0 is the cycle start is presented; lat is the
  // cycle index at which done is seen. Operands are scrambled after the
  // start edge.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit hold, output logic [N-1:0] res, output int lat,
                        output int stalls, output int dones, output bit busy_after,
                        output bit stall_after);
    lat = -1; stalls = 0; dones = 0; res = '0; busy_after = 1'b1; stall_after = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (lat >= 0) begin
        busy_after  = busy;
        stall_after = stall_E;
        break;
      end
      if (stall_E) stalls++;
      if (done) begin
        dones++;
        lat = c;
        res = result;
      end
      @(negedge clk);
      if (!hold) start = 1'b0;
      srcA = {$urandom, $urandom};
      srcB = {$urandom, $urandom};
    end
    start = 1'b0;
  endtask

  logic [N-1:0] res;
  int           lat, stalls, dones, seen;
  bit           busy_after, stall_after;
  logic [1:0]   ro;
  logic [N-1:0] ra, rb;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_result", result, '0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_stall", {63'd0, stall_E}, 64'd0);
    reset = 1'b0;

    vecs[0] = '{2'b00, 64'd10, 64'd20, 64'd200, 65};
    vecs[1] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 65};
    vecs[3] = '{2'b10, 64'd100, 64'd7, 64'd14, 65};
    vecs[4] = '{2'b10, 64'h8000_0000_0000_0000, 64'd2, 64'h4000_0000_0000_0000, 65};
    vecs[5] = '{2'b10, 64'd55, 64'd0, 64'd0, 1};
    vecs[6] = '{2'b11, 64'd6, 64'd7, 64'd42, 65};
    vecs[7] = '{2'b01, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65};
    vecs[8] = '{2'b10, 64'd5, 64'd9, 64'd0, 65};
    vecs[9] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65};

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, lat, stalls, dones, busy_after, stall_after);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_stall_cycles", i), 64'(stalls), 64'(vecs[i].lat == 1 ? 1 : 65));
      chk($sformatf("vec%0d_done_count", i), 64'(dones), 64'd1);
      chk($sformatf("vec%0d_busy_after", i), {63'd0, busy_after}, 64'd0);
    end

    // Leave 14 in result, then flush at RUN cycle 30.
    run_op(2'b10, 64'd100, 64'd7, 1'b0, res, lat, stalls, dones, busy_after, stall_after);
    chk("pre_flush_result", res, 64'd14);
    @(negedge clk);
    start = 1'b1; op = 2'b00; srcA = 64'd3; srcB = 64'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_run_stall", {63'd0, stall_E}, 64'd1);
    chk("flush_run_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy_after", {63'd0, busy}, 64'd0);
    chk("flush_result_kept", result, 64'd14);
    seen = 0;
    repeat (70) begin @(negedge clk); #1; if (done) seen++; end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_result_still", result, 64'd14);

    // Reset at RUN cycle 10.
    @(negedge clk);
    start = 1'b1; op = 2'b00; srcA = 64'd7; srcB = 64'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_result", result, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (70) begin @(negedge clk); #1; if (done) seen++; end
    chk("midreset_no_done", 64'(seen), 64'd0);

    // start held through a full MUL 3*4.
    run_op(2'b00, 64'd3, 64'd4, 1'b1, res, lat, stalls, dones, busy_after, stall_after);
    chk("hold_result", res, 64'd12);
    chk("hold_latency", 64'(lat), 64'd65);
    chk("hold_done_count", 64'(dones), 64'd1);
    chk("hold_stall_cycles", 64'(stalls), 64'd65);
    chk("hold_idle_after", {63'd0, busy_after}, 64'd0);
    chk("hold_restart_req", {63'd0, stall_after}, 64'd1);

    // start with flush in IDLE: flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; srcA = 64'd2; srcB = 64'd2;
    #1;
    chk("startflush_stall", {63'd0, stall_E}, 64'd0);
    @(negedge clk);
    #1;
    chk("startflush_busy", {63'd0, busy}, 64'd0);
    chk("startflush_done", {63'd0, done}, 64'd0);
    start = 1'b0; flush = 1'b0;

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1, 2:    rb = 64'($urandom_range(1, 1000));
        default: rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      run_op(ro, ra, rb, 1'b0, res, lat, stalls, dones, busy_after, stall_after);
      chk($sformatf("rand%0d_op%0d_result", i, ro), res, model(ro, ra, rb));
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(model_lat(ro, rb)));
      chk($sformatf("rand%0d_busy_after", i), {63'd0, busy_after}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
